// File: rtl/io_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM encoding,
// status word layout and the IO word-address bit that selects the UART.
package io_uart_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int STAT_FULL     = 8;
  localparam int STAT_BUSY     = 9;
  localparam int STAT_OVF      = 10;
  localparam int UART_ADDR_BIT = 1;

  typedef struct packed {
    logic ovf;
    logic busy;
    logic full;
  } uart_status_t;

  function automatic logic [31:0] status_word(input uart_status_t st);
    logic [31:0] w;
    w            = '0;
    w[STAT_FULL] = st.full;
    w[STAT_BUSY] = st.busy;
    w[STAT_OVF]  = st.ovf;
    return w;
  endfunction

endpackage

// File: rtl/io_uart_tx_if.sv
// CPU-side IO bus seen by the UART: select, write/read strobes and data.
interface io_uart_tx_if;
  logic        sel;
  logic        mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rstrb;
  logic [31:0] mem_rdata;

  modport master (output sel, mem_wstrb, mem_wdata, mem_rstrb, input mem_rdata);
  modport slave  (input sel, mem_wstrb, mem_wdata, mem_rstrb, output mem_rdata);
endinterface

// File: rtl/io_uart_tx_fifo.sv
// io_fifo: power-of-two circular byte FIFO with show-ahead output.
// Push while full and pop while empty are ignored.
module io_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          wr_en, rd_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;
  assign dout  = mem[rptr];

  // Storage carries no reset; only pointers and count define contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with status register.
// Define UART_FIFO_EN for a FIFO_DEPTH-entry transmit FIFO; otherwise one holding register.
module io_uart_tx
  import io_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic         clk,
  input  logic         reset,
  io_uart_tx_if.slave  bus,
  output logic         tx
);
  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  uart_state_e   state, state_nx;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          tx_nx;
  logic          baud_done;

  logic       wr, rd, push, pop, drop;
  logic       full, empty, busy, ovf;
  logic [7:0] dout;

  assign wr        = bus.sel & bus.mem_wstrb;
  assign rd        = bus.sel & bus.mem_rstrb;
  // full is the pre-pop value, so a write meeting a full store is dropped even on a pop cycle
  assign push      = wr & ~full;
  assign drop      = wr & full;
  assign pop       = (state == ST_IDLE) & ~empty;
  assign busy      = ~empty | (state != ST_IDLE);
  assign baud_done = (baud_cnt == '0);

`ifdef UART_FIFO_EN
  io_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (bus.mem_wdata[7:0]),
    .dout  (dout),
    .full  (full),
    .empty (empty)
  );
`else
  localparam int UNUSED_FIFO_DEPTH = FIFO_DEPTH;
  logic hold_vld;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_vld <= 1'b0;
      dout     <= '0;
    end else if (push) begin
      hold_vld <= 1'b1;
      dout     <= bus.mem_wdata[7:0];
    end else if (pop) begin
      hold_vld <= 1'b0;
    end
  end

  assign full  = hold_vld;
  assign empty = ~hold_vld;
`endif

  logic unused_wdata;
  assign unused_wdata = ^bus.mem_wdata[31:8];

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (!empty)                        state_nx = ST_START;
      ST_START: if (baud_done)                     state_nx = ST_DATA;
      ST_DATA:  if (baud_done && bit_idx == 3'd7)  state_nx = ST_STOP;
      ST_STOP:  if (baud_done)                     state_nx = ST_IDLE;
      default:                                     state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_nx = 1'b1;
    case (state)
      ST_START: tx_nx = 1'b0;
      ST_DATA:  tx_nx = shift[0];
      default:  tx_nx = 1'b1;
    endcase
  end

  // tx is registered so the line is glitch-free; it lags the state by one clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      tx <= tx_nx;
      if (state == ST_IDLE) begin
        if (pop) begin
          shift    <= dout;
          baud_cnt <= BAUD_MAX;
          bit_idx  <= '0;
        end
      end else if (baud_done) begin
        baud_cnt <= BAUD_MAX;
        if (state == ST_DATA) begin
          shift   <= shift >> 1;
          bit_idx <= bit_idx + 3'd1;
        end else begin
          bit_idx <= '0;
        end
      end else begin
        baud_cnt <= baud_cnt - 1'b1;
      end
    end
  end

  // A read captures the pre-clear flag; an overflowing write on the same edge keeps it set.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf           <= 1'b0;
      bus.mem_rdata <= '0;
    end else begin
      if (rd) bus.mem_rdata <= status_word('{ovf: ovf, busy: busy, full: full});
      if (drop)    ovf <= 1'b1;
      else if (rd) ovf <= 1'b0;
    end
  end

endmodule
